alu_pipe: RTL



---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_pipe_mul_seq.sv | 77 +++++++
 rtl/alu_pipe.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: op codes, FSM state encoding and op-class helper.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLL   = 4'd6,
        OP_SRL   = 4'd7,
        OP_SRA   = 4'd8,
        OP_SLT   = 4'd9,
        OP_SLTU  = 4'd10,
        OP_PASSB = 4'd11,
        OP_MUL   = 4'd12,
        OP_MULH  = 4'd13,
        OP_MULHU = 4'd14,
        OP_ILL   = 4'd15
    } alu_op_e;

    typedef logic [1:0] alu_state_e;
    localparam alu_state_e IDLE = 2'd0;
    localparam alu_state_e MUL  = 2'd1;
    localparam alu_state_e FIX  = 2'd2;

    localparam int OP_W = 4;

    function automatic logic is_mul_op(input alu_op_e o);
        return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_pipe_mul_seq.sv
// Iterative radix-2 shift-add multiplier: one partial product per cycle, then a fix-up
// cycle that applies the result sign and picks the requested half.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            signed_en,
    input  logic            hi_sel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] p
);

    localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

    alu_state_e        phase;
    logic [SHW-1:0]    cnt;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] acc;
    logic              neg;
    logic              hi;
    logic [XLEN:0]     madd;
    logic [2*XLEN-1:0] prod;

    // Upper half accumulates; the multiplier sits in the lower half and shifts out LSB-first.
    assign madd = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            hi    <= 1'b0;
        end else begin
            case (phase)
                IDLE: begin
                    if (start) begin
                        mcand <= (signed_en && a[XLEN-1]) ? -a : a;
                        acc   <= {{XLEN{1'b0}}, ((signed_en && b[XLEN-1]) ? -b : b)};
                        neg   <= signed_en && (a[XLEN-1] ^ b[XLEN-1]);
                        hi    <= hi_sel;
                        cnt   <= '0;
                        phase <= MUL;
                    end
                end
                MUL: begin
                    acc <= {madd, acc[XLEN-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        phase <= FIX;
                    end
                end
                FIX: begin
                    phase <= IDLE;
                end
                default: begin
                    phase <= IDLE;
                end
            endcase
        end
    end

    assign prod = neg ? -acc : acc;
    assign p    = hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    assign busy = (phase != IDLE);
    assign done = (phase == FIX);

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and flags. Define ALU_MUL_EN to build the
// multi-cycle MUL/MULH/MULHU path; without it those ops report err like op 15.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] r,
    output logic            z,
    output logic            v,
    output logic            c,
    output logic            err
);

    alu_op_e         op_e;
    alu_state_e      state;
    logic            accept;
    logic            load;
    logic [XLEN-1:0] bb;
    logic [XLEN:0]   sum;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_r;
    logic            alu_v, alu_c, alu_err;
    logic [XLEN-1:0] ld_r;
    logic            ld_v, ld_c, ld_err;

    assign op_e     = alu_op_e'(op);
    assign shamt    = b[SHW-1:0];
    assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // SUB is a + ~b + 1, so the carry-out is the inverse of the unsigned borrow.
    always_comb begin
        bb      = (op_e == OP_SUB) ? ~b : b;
        sum     = {1'b0, a} + {1'b0, bb} + {{XLEN{1'b0}}, (op_e == OP_SUB)};
        alu_r   = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        alu_err = 1'b0;
        case (op_e)
            OP_ADD, OP_SUB: begin
                alu_r = sum[XLEN-1:0];
                alu_v = (a[XLEN-1] == bb[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
                alu_c = (op_e == OP_SUB) ? ~sum[XLEN] : sum[XLEN];
            end
            OP_AND:   alu_r = a & b;
            OP_OR:    alu_r = a | b;
            OP_XOR:   alu_r = a ^ b;
            OP_NOR:   alu_r = ~(a | b);
            OP_SLL:   alu_r = a << shamt;
            OP_SRL:   alu_r = a >> shamt;
            OP_SRA:   alu_r = $signed(a) >>> shamt;
            OP_SLT:   alu_r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  alu_r = {{(XLEN-1){1'b0}}, (a < b)};
            OP_PASSB: alu_r = b;
            default:  alu_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    logic            mul_busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_p;

    alu_mul_seq #(
        .XLEN(XLEN),
        .SHW (SHW)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start    (accept && is_mul_op(op_e)),
        .a        (a),
        .b        (b),
        .signed_en(op_e == OP_MULH),
        .hi_sel   (op_e != OP_MUL),
        .busy     (mul_busy),
        .done     (mul_done),
        .p        (mul_p)
    );

    assign state  = mul_done ? FIX : (mul_busy ? MUL : IDLE);
    assign load   = (accept && !is_mul_op(op_e)) || mul_done;
    assign ld_r   = mul_done ? mul_p : alu_r;
    assign ld_v   = mul_done ? 1'b0 : alu_v;
    assign ld_c   = mul_done ? 1'b0 : alu_c;
    assign ld_err = mul_done ? 1'b0 : alu_err;
`else
    assign state  = IDLE;
    assign load   = accept;
    assign ld_r   = alu_r;
    assign ld_v   = alu_v;
    assign ld_c   = alu_c;
    assign ld_err = alu_err;
`endif

    // A load wins over a drain on the same edge, so back-to-back results keep out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            r         <= '0;
            z         <= 1'b0;
            v         <= 1'b0;
            c         <= 1'b0;
            err       <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            r         <= ld_r;
            z         <= (ld_r == '0);
            v         <= ld_v;
            c         <= ld_c;
            err       <= ld_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
